rv32i_decode_exec_wb: RTL and testbench

- Decode, execute, data-memory and write-back datapath of the multi-cycle RV32I core (fetch → decode → execute → write).
- The top-level sequencer owns the PC, instruction memory and the 32×32 register file. It strobes this block once per stage.
- The block decodes the fetched instruction, computes the ALU result and next PC, and performs loads/stores on an internal data memory.
- It presents the register-file write request combinationally.

---
 rtl/rv32i_decode_exec_wb.sv | 236 +++++++++++++++++++++++
 tb/tb_rv32i_decode_exec_wb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_decode_exec_wb.sv
// rv32i_decode_exec_wb
// Decode, execute, data-memory and write-back datapath of a multi-cycle RV32I
// core. The external sequencer owns PC, instruction memory and register file
// and strobes this block once per stage.
// Ports:
//   CLK, RSTN          clock, synchronous active-high reset (RSTN=1 resets)
//   DEC_EN, EXE_EN     decode / execute stage strobes
//   INSTRUCTION, PC    fetched word and its byte address (sampled on DEC_EN)
//   RS1_ADDR/RS2_ADDR  source register indices from the decode register
//   RS1_DATA/RS2_DATA  register-file values, valid in the EXE_EN cycle
//   JUMP_DEST          registered next PC
//   WRITE_ENABLE/RD/DATA  combinational register write-back request
module rv32i_decode_exec_wb #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        DEC_EN,
  input  logic        EXE_EN,
  input  logic [31:0] INSTRUCTION,
  input  logic [31:0] PC,
  output logic [4:0]  RS1_ADDR,
  output logic [4:0]  RS2_ADDR,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  output logic [31:0] JUMP_DEST,
  output logic        WRITE_ENABLE,
  output logic [4:0]  WRITE_RD,
  output logic [31:0] WRITE_DATA
);

  localparam int AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_IMM, CLS_OP
  } op_class_t;

  // decode register
  op_class_t   d_class;
  logic [31:0] d_pc, d_imm;
  logic [2:0]  d_funct3;
  logic        d_f7b5;
  logic [4:0]  d_rd, d_rs1, d_rs2;

  // execute / write-back registers
  logic [31:0] result_q, jump_q, load_word_q;
  logic [4:0]  wb_rd_q;
  logic        wb_en_q, is_load_q;
  logic [2:0]  load_f3_q;
  logic [1:0]  addr_lo_q;

  logic [31:0] dmem [DMEM_WORDS];

  // Combinational decode of the incoming word: class and format immediate.
  op_class_t   dec_class;
  logic [31:0] dec_imm;
  always_comb begin
    dec_class = CLS_NOP;
    dec_imm   = 32'd0;
    case (INSTRUCTION[6:0])
      7'b0110111: begin dec_class = CLS_LUI;    dec_imm = {INSTRUCTION[31:12], 12'd0}; end
      7'b0010111: begin dec_class = CLS_AUIPC;  dec_imm = {INSTRUCTION[31:12], 12'd0}; end
      7'b1101111: begin
        dec_class = CLS_JAL;
        dec_imm = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                   INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
      end
      7'b1100111: begin dec_class = CLS_JALR; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]}; end
      7'b1100011: begin
        dec_class = CLS_BRANCH;
        dec_imm = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                   INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
      end
      7'b0000011: begin dec_class = CLS_LOAD; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]}; end
      7'b0100011: begin
        dec_class = CLS_STORE;
        dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
      end
      7'b0010011: begin dec_class = CLS_IMM; dec_imm = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]}; end
      7'b0110011: begin dec_class = CLS_OP; dec_imm = 32'd0; end
      default:    begin dec_class = CLS_NOP; dec_imm = 32'd0; end
    endcase
  end

  // Decode register: loads on DEC_EN; reset makes it a NOP at PC 0.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      d_class  <= CLS_NOP;
      d_pc     <= 32'd0;
      d_imm    <= 32'd0;
      d_funct3 <= 3'd0;
      d_f7b5   <= 1'b0;
      d_rd     <= 5'd0;
      d_rs1    <= 5'd0;
      d_rs2    <= 5'd0;
    end else if (DEC_EN) begin
      d_class  <= dec_class;
      d_pc     <= PC;
      d_imm    <= dec_imm;
      d_funct3 <= INSTRUCTION[14:12];
      d_f7b5   <= INSTRUCTION[30];
      d_rd     <= INSTRUCTION[11:7];
      d_rs1    <= INSTRUCTION[19:15];
      d_rs2    <= INSTRUCTION[24:20];
    end
  end

  assign RS1_ADDR = d_rs1;
  assign RS2_ADDR = d_rs2;

  logic [31:0] op_b, alu_out, pc_plus4, eff_addr;
  assign op_b     = (d_class == CLS_OP) ? RS2_DATA : d_imm;
  assign pc_plus4 = d_pc + 32'd4;
  assign eff_addr = RS1_DATA + d_imm;

  // ALU shared by OP and OP-IMM; SUB only exists in the register form.
  always_comb begin
    alu_out = 32'd0;
    case (d_funct3)
      3'b000: alu_out = (d_class == CLS_OP && d_f7b5) ? RS1_DATA - op_b : RS1_DATA + op_b;
      3'b001: alu_out = RS1_DATA << op_b[4:0];
      3'b010: alu_out = {31'd0, $signed(RS1_DATA) < $signed(op_b)};
      3'b011: alu_out = {31'd0, RS1_DATA < op_b};
      3'b100: alu_out = RS1_DATA ^ op_b;
      3'b101: begin
        if (d_f7b5) alu_out = $signed(RS1_DATA) >>> op_b[4:0];
        else        alu_out = RS1_DATA >> op_b[4:0];
      end
      3'b110: alu_out = RS1_DATA | op_b;
      3'b111: alu_out = RS1_DATA & op_b;
    endcase
  end

  // Branch condition, result and next-PC selection.
  logic        taken;
  logic [31:0] exe_result, exe_jump;
  logic        exe_we;
  always_comb begin
    taken = 1'b0;
    case (d_funct3)
      3'b000:  taken = (RS1_DATA == RS2_DATA);
      3'b001:  taken = (RS1_DATA != RS2_DATA);
      3'b100:  taken = ($signed(RS1_DATA) <  $signed(RS2_DATA));
      3'b101:  taken = ($signed(RS1_DATA) >= $signed(RS2_DATA));
      3'b110:  taken = (RS1_DATA <  RS2_DATA);
      3'b111:  taken = (RS1_DATA >= RS2_DATA);
      default: taken = 1'b0;
    endcase
    exe_result = alu_out;
    exe_jump   = pc_plus4;
    case (d_class)
      CLS_LUI:    exe_result = d_imm;
      CLS_AUIPC:  exe_result = d_pc + d_imm;
      CLS_JAL:    begin exe_result = pc_plus4; exe_jump = d_pc + d_imm; end
      CLS_JALR:   begin exe_result = pc_plus4; exe_jump = eff_addr & ~32'd1; end
      CLS_BRANCH: if (taken) exe_jump = d_pc + d_imm;
      default:    ;
    endcase
    exe_we = (d_rd != 5'd0) &&
             (d_class inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_IMM, CLS_OP});
  end

  // Store byte enables; data is replicated so every lane sees its bytes.
  logic [3:0]    byte_en;
  logic [31:0]   store_data;
  logic [AW-1:0] mem_index;
  assign mem_index = eff_addr[AW+1:2];
  always_comb begin
    byte_en    = 4'b0000;
    store_data = RS2_DATA;
    if (d_class == CLS_STORE) begin
      case (d_funct3)
        3'b000: begin byte_en = 4'b0001 << eff_addr[1:0]; store_data = {4{RS2_DATA[7:0]}}; end
        3'b001: begin byte_en = eff_addr[1] ? 4'b1100 : 4'b0011; store_data = {2{RS2_DATA[15:0]}}; end
        3'b010: byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
  end

  // Data memory is never reset; reset still blocks a store in its cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN && EXE_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[mem_index][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  // Execute registers feeding JUMP_DEST and the write-back request.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      result_q    <= 32'd0;
      jump_q      <= 32'd0;
      load_word_q <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_en_q     <= 1'b0;
      is_load_q   <= 1'b0;
      load_f3_q   <= 3'd0;
      addr_lo_q   <= 2'd0;
    end else if (EXE_EN) begin
      result_q  <= exe_result;
      jump_q    <= exe_jump;
      wb_rd_q   <= d_rd;
      wb_en_q   <= exe_we;
      is_load_q <= (d_class == CLS_LOAD);
      load_f3_q <= d_funct3;
      addr_lo_q <= eff_addr[1:0];
      if (d_class == CLS_LOAD) load_word_q <= dmem[mem_index];
    end
  end

  // Load lane extraction happens on the write-back side of the register.
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  always_comb begin
    lane_byte  = load_word_q[{addr_lo_q, 3'b000} +: 8];
    lane_half  = addr_lo_q[1] ? load_word_q[31:16] : load_word_q[15:0];
    WRITE_DATA = result_q;
    if (is_load_q) begin
      case (load_f3_q)
        3'b000:  WRITE_DATA = {{24{lane_byte[7]}}, lane_byte};
        3'b001:  WRITE_DATA = {{16{lane_half[15]}}, lane_half};
        3'b100:  WRITE_DATA = {24'd0, lane_byte};
        3'b101:  WRITE_DATA = {16'd0, lane_half};
        default: WRITE_DATA = load_word_q;
      endcase
    end
  end

  assign WRITE_ENABLE = wb_en_q;
  assign WRITE_RD     = wb_rd_q;
  assign JUMP_DEST    = jump_q;

endmodule

// File: tb/tb_rv32i_decode_exec_wb.sv
// tb_rv32i_decode_exec_wb
// Self-checking bench for rv32i_decode_exec_wb. Expected write-back results are
// pushed to a scoreboard queue when an instruction is issued and popped when
// the execute stage presents its outputs.
module tb_rv32i_decode_exec_wb;

  logic        clk = 1'b0;
  logic        rstn, dec_en, exe_en;
  logic [31:0] instruction, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, write_rd;
  logic [31:0] jump_dest, write_data;
  logic        write_enable;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data, jd;
    bit          chk_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data, jd;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];

  rv32i_decode_exec_wb #(.DMEM_WORDS(1024)) dut (
    .CLK(clk), .RSTN(rstn), .DEC_EN(dec_en), .EXE_EN(exe_en),
    .INSTRUCTION(instruction), .PC(pc),
    .RS1_ADDR(rs1_addr), .RS2_ADDR(rs2_addr),
    .RS1_DATA(rs1_data), .RS2_DATA(rs2_data),
    .JUMP_DEST(jump_dest),
    .WRITE_ENABLE(write_enable), .WRITE_RD(write_rd), .WRITE_DATA(write_data)
  );

  always #5 clk = ~clk;

  // instruction encoders
  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // decode then execute one instruction
  task automatic issue(input logic [31:0] instr, input logic [31:0] ipc,
                       input logic [31:0] r1, input logic [31:0] r2);
    instruction = instr;
    pc          = ipc;
    dec_en      = 1'b1;
    step();
    dec_en   = 1'b0;
    rs1_data = r1;
    rs2_data = r2;
    exe_en   = 1'b1;
    step();
    exe_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1; dec_en = 1'b0; exe_en = 1'b0;
    instruction = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    step(); step();
    rstn = 1'b0;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset we: got %b expected 0", write_enable); end
    checks++; if (write_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset rd: got %0d expected 0", write_rd); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("[TB] FAIL reset data: got %h expected 0", write_data); end
    checks++; if (jump_dest !== 32'd0) begin errors++; $display("[TB] FAIL reset jd: got %h expected 0", jump_dest); end
    checks++; if (rs1_addr !== 5'd0 || rs2_addr !== 5'd0) begin
      errors++; $display("[TB] FAIL reset rs_addr: got %0d/%0d expected 0/0", rs1_addr, rs2_addr);
    end
  endtask

  task automatic test_operand_addr();
    instruction = 32'h00E7C663; pc = 32'h24; dec_en = 1'b1;
    step();
    dec_en = 1'b0;
    checks++; if (rs1_addr !== 5'd15) begin errors++; $display("[TB] FAIL rs1_addr: got %0d expected 15", rs1_addr); end
    checks++; if (rs2_addr !== 5'd14) begin errors++; $display("[TB] FAIL rs2_addr: got %0d expected 14", rs2_addr); end
    instruction = 32'hFFFFFFFF;
    step();
    checks++; if (rs1_addr !== 5'd15) begin errors++; $display("[TB] FAIL rs1_addr hold: got %0d expected 15", rs1_addr); end
  endtask

  task automatic test_alu();
    vec_t v[14];
    exp_t e;
    v = '{
      '{32'h01400513,                      32'h0,   32'h0,        32'h0,  1'b1, 5'd10, 32'd20,       32'h4,   1'b1},
      '{enc_r(7'h20, 2, 1, 3'd0, 5),       32'h100, 32'h80000000, 32'h1,  1'b1, 5'd5,  32'h7FFFFFFF, 32'h104, 1'b1},
      '{enc_i(12'h404, 1, 3'd5, 6, 7'h13), 32'h104, 32'h80000000, 32'h1,  1'b1, 5'd6,  32'hF8000000, 32'h108, 1'b1},
      '{enc_r(7'h00, 2, 1, 3'd3, 7),       32'h108, 32'h80000000, 32'h1,  1'b1, 5'd7,  32'h0,        32'h10C, 1'b1},
      '{enc_r(7'h00, 2, 1, 3'd2, 8),       32'h10C, 32'h80000000, 32'h1,  1'b1, 5'd8,  32'h1,        32'h110, 1'b1},
      '{enc_r(7'h00, 2, 1, 3'd0, 9),       32'h110, 32'hFFFFFFFF, 32'h1,  1'b1, 5'd9,  32'h0,        32'h114, 1'b1},
      '{enc_r(7'h00, 2, 1, 3'd5, 13),      32'h114, 32'h80000000, 32'h24, 1'b1, 5'd13, 32'h08000000, 32'h118, 1'b1},
      '{{20'h12345, 5'd11, 7'h37},         32'h118, 32'h0,        32'h0,  1'b1, 5'd11, 32'h12345000, 32'h11C, 1'b1},
      '{{20'h00001, 5'd12, 7'h17},         32'h40,  32'h0,        32'h0,  1'b1, 5'd12, 32'h1040,     32'h44,  1'b1},
      '{32'hFFFFFFFF,                      32'h80,  32'h0,        32'h0,  1'b0, 5'd0,  32'h0,        32'h84,  1'b0},
      '{enc_i(12'd5, 0, 3'd0, 0, 7'h13),   32'h84,  32'h0,        32'h0,  1'b0, 5'd0,  32'h0,        32'h88,  1'b0},
      '{enc_i(12'hFFF, 1, 3'd4, 14, 7'h13),32'h88,  32'h0F0F0F0F, 32'h0,  1'b1, 5'd14, 32'hF0F0F0F0, 32'h8C,  1'b1},
      '{enc_i(12'hFFF, 1, 3'd2, 15, 7'h13),32'h8C,  32'h80000000, 32'h0,  1'b1, 5'd15, 32'h1,        32'h90,  1'b1},
      '{enc_i(12'hFFF, 1, 3'd3, 16, 7'h13),32'h90,  32'h5,        32'h0,  1'b1, 5'd16, 32'h1,        32'h94,  1'b1}
    };
    foreach (v[i]) begin
      sb.push_back('{v[i].we, v[i].rd, v[i].data, v[i].jd, v[i].chk_data});
      issue(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      e = sb.pop_front();
      checks++; if (write_enable !== e.we) begin errors++; $display("[TB] FAIL alu[%0d] we: got %b expected %b", i, write_enable, e.we); end
      if (e.we) begin
        checks++; if (write_rd !== e.rd) begin errors++; $display("[TB] FAIL alu[%0d] rd: got %0d expected %0d", i, write_rd, e.rd); end
      end
      if (e.chk_data) begin
        checks++; if (write_data !== e.data) begin errors++; $display("[TB] FAIL alu[%0d] data: got %h expected %h", i, write_data, e.data); end
      end
      checks++; if (jump_dest !== e.jd) begin errors++; $display("[TB] FAIL alu[%0d] jd: got %h expected %h", i, jump_dest, e.jd); end
    end
  endtask

  task automatic test_control_flow();
    vec_t v[12];
    exp_t e;
    v = '{
      '{32'h074000EF,                       32'h0,  32'h0,        32'h0, 1'b1, 5'd1, 32'h4,  32'h74, 1'b1},
      '{32'h00008067,                       32'h74, 32'h91,       32'h0, 1'b0, 5'd0, 32'h0,  32'h90, 1'b0},
      '{enc_i(12'hFFD, 1, 3'd0, 5, 7'h67),  32'h20, 32'h100,      32'h0, 1'b1, 5'd5, 32'h24, 32'hFC, 1'b1},
      '{32'h00E7C663,                       32'h24, 32'h1,        32'h5, 1'b0, 5'd0, 32'h0,  32'h30, 1'b0},
      '{32'h00E7C663,                       32'h24, 32'h5,        32'h1, 1'b0, 5'd0, 32'h0,  32'h28, 1'b0},
      '{32'h00E7C663,                       32'h24, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, 32'h0,  32'h30, 1'b0},
      '{enc_b(13'd12, 14, 15, 3'd6),        32'h24, 32'hFFFFFFFF, 32'h1, 1'b0, 5'd0, 32'h0,  32'h28, 1'b0},
      '{enc_b(13'd12, 14, 15, 3'd1),        32'h24, 32'h7,        32'h7, 1'b0, 5'd0, 32'h0,  32'h28, 1'b0},
      '{enc_b(13'd12, 14, 15, 3'd0),        32'h24, 32'h7,        32'h7, 1'b0, 5'd0, 32'h0,  32'h30, 1'b0},
      '{enc_b(13'd12, 14, 15, 3'd5),        32'h24, 32'h5,        32'h5, 1'b0, 5'd0, 32'h0,  32'h30, 1'b0},
      '{enc_b(13'h1FF8, 14, 15, 3'd7),      32'h40, 32'h5,        32'h5, 1'b0, 5'd0, 32'h0,  32'h38, 1'b0},
      '{enc_b(13'd12, 14, 15, 3'd5),        32'h24, 32'h80000000, 32'h1, 1'b0, 5'd0, 32'h0,  32'h28, 1'b0}
    };
    foreach (v[i]) begin
      sb.push_back('{v[i].we, v[i].rd, v[i].data, v[i].jd, v[i].chk_data});
      issue(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      e = sb.pop_front();
      checks++; if (write_enable !== e.we) begin errors++; $display("[TB] FAIL flow[%0d] we: got %b expected %b", i, write_enable, e.we); end
      if (e.we) begin
        checks++; if (write_rd !== e.rd) begin errors++; $display("[TB] FAIL flow[%0d] rd: got %0d expected %0d", i, write_rd, e.rd); end
      end
      if (e.chk_data) begin
        checks++; if (write_data !== e.data) begin errors++; $display("[TB] FAIL flow[%0d] data: got %h expected %h", i, write_data, e.data); end
      end
      checks++; if (jump_dest !== e.jd) begin errors++; $display("[TB] FAIL flow[%0d] jd: got %h expected %h", i, jump_dest, e.jd); end
    end
  endtask

  task automatic test_memory();
    vec_t v[14];
    exp_t e;
    v = '{
      '{32'h00112E23,                     32'h200, 32'd500,  32'h1234ABCD, 1'b0, 5'd0, 32'h0,        32'h204, 1'b0},
      '{32'h01C12083,                     32'h204, 32'd500,  32'h0,        1'b1, 5'd1, 32'h1234ABCD, 32'h208, 1'b1},
      '{enc_i(12'd28, 2, 3'd0, 1, 7'h03), 32'h208, 32'd500,  32'h0,        1'b1, 5'd1, 32'hFFFFFFCD, 32'h20C, 1'b1},
      '{enc_i(12'd28, 2, 3'd4, 1, 7'h03), 32'h20C, 32'd500,  32'h0,        1'b1, 5'd1, 32'h000000CD, 32'h210, 1'b1},
      '{enc_i(12'd28, 2, 3'd1, 1, 7'h03), 32'h210, 32'd502,  32'h0,        1'b1, 5'd1, 32'h00001234, 32'h214, 1'b1},
      '{enc_s(12'd28, 1, 2, 3'd0),        32'h214, 32'd503,  32'h000000AB, 1'b0, 5'd0, 32'h0,        32'h218, 1'b0},
      '{enc_i(12'd28, 2, 3'd5, 3, 7'h03), 32'h218, 32'd502,  32'h0,        1'b1, 5'd3, 32'h0000AB34, 32'h21C, 1'b1},
      '{enc_i(12'd28, 2, 3'd1, 3, 7'h03), 32'h21C, 32'd502,  32'h0,        1'b1, 5'd3, 32'hFFFFAB34, 32'h220, 1'b1},
      '{32'h01C12083,                     32'h220, 32'd500,  32'h0,        1'b1, 5'd1, 32'hAB34ABCD, 32'h224, 1'b1},
      '{enc_s(12'd28, 1, 2, 3'd1),        32'h224, 32'd501,  32'hFFFF5555, 1'b0, 5'd0, 32'h0,        32'h228, 1'b0},
      '{32'h01C12083,                     32'h228, 32'd500,  32'h0,        1'b1, 5'd1, 32'hAB345555, 32'h22C, 1'b1},
      '{enc_i(12'd28, 2, 3'd1, 4, 7'h03), 32'h22C, 32'd500,  32'h0,        1'b1, 5'd4, 32'h00005555, 32'h230, 1'b1},
      '{32'h00112E23,                     32'h230, 32'd4596, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0,        32'h234, 1'b0},
      '{32'h01C12083,                     32'h234, 32'd500,  32'h0,        1'b1, 5'd1, 32'hCAFEF00D, 32'h238, 1'b1}
    };
    foreach (v[i]) begin
      sb.push_back('{v[i].we, v[i].rd, v[i].data, v[i].jd, v[i].chk_data});
      issue(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      e = sb.pop_front();
      checks++; if (write_enable !== e.we) begin errors++; $display("[TB] FAIL mem[%0d] we: got %b expected %b", i, write_enable, e.we); end
      if (e.we) begin
        checks++; if (write_rd !== e.rd) begin errors++; $display("[TB] FAIL mem[%0d] rd: got %0d expected %0d", i, write_rd, e.rd); end
      end
      if (e.chk_data) begin
        checks++; if (write_data !== e.data) begin errors++; $display("[TB] FAIL mem[%0d] data: got %h expected %h", i, write_data, e.data); end
      end
      checks++; if (jump_dest !== e.jd) begin errors++; $display("[TB] FAIL mem[%0d] jd: got %h expected %h", i, jump_dest, e.jd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [3];
    logic [31:0] pcs    [3];
    exp_t        exps   [3];
    exp_t        e;
    instrs[0] = enc_i(12'd7, 0, 3'd0, 3, 7'h13);   pcs[0] = 32'h10; exps[0] = '{1'b1, 5'd3, 32'd7,        32'h14, 1'b1};
    instrs[1] = enc_i(12'hFFF, 0, 3'd0, 4, 7'h13); pcs[1] = 32'h14; exps[1] = '{1'b1, 5'd4, 32'hFFFFFFFF, 32'h18, 1'b1};
    instrs[2] = {20'hABCDE, 5'd5, 7'h37};          pcs[2] = 32'h18; exps[2] = '{1'b1, 5'd5, 32'hABCDE000, 32'h1C, 1'b1};
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    for (int c = 0; c < 4; c++) begin
      dec_en = (c < 3);
      exe_en = (c > 0);
      if (c < 3) begin
        instruction = instrs[c];
        pc          = pcs[c];
        sb.push_back(exps[c]);
      end
      step();
      if (c > 0) begin
        e = sb.pop_front();
        checks++; if (write_enable !== e.we) begin errors++; $display("[TB] FAIL b2b[%0d] we: got %b expected %b", c, write_enable, e.we); end
        checks++; if (write_rd !== e.rd) begin errors++; $display("[TB] FAIL b2b[%0d] rd: got %0d expected %0d", c, write_rd, e.rd); end
        checks++; if (write_data !== e.data) begin errors++; $display("[TB] FAIL b2b[%0d] data: got %h expected %h", c, write_data, e.data); end
        checks++; if (jump_dest !== e.jd) begin errors++; $display("[TB] FAIL b2b[%0d] jd: got %h expected %h", c, jump_dest, e.jd); end
      end
    end
    dec_en = 1'b0;
    exe_en = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL b2b queue: got %0d entries expected 0", sb.size()); end
    step(); step();
    checks++; if (write_data !== 32'hABCDE000 || write_enable !== 1'b1) begin
      errors++; $display("[TB] FAIL hold: got we=%b data=%h expected we=1 data=abcde000", write_enable, write_data);
    end
  endtask

  task automatic test_reset_midstream();
    issue(enc_i(12'd9, 0, 3'd0, 10, 7'h13), 32'h300, 32'd0, 32'd0);
    instruction = 32'h00112E23;
    pc          = 32'h304;
    rs1_data    = 32'd500;
    rs2_data    = 32'h11111111;
    dec_en = 1'b1; exe_en = 1'b1; rstn = 1'b1;
    step();
    rstn = 1'b0; dec_en = 1'b0; exe_en = 1'b0;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL midrst we: got %b expected 0", write_enable); end
    checks++; if (jump_dest !== 32'd0) begin errors++; $display("[TB] FAIL midrst jd: got %h expected 0", jump_dest); end
    checks++; if (write_data !== 32'd0) begin errors++; $display("[TB] FAIL midrst data: got %h expected 0", write_data); end
    checks++; if (rs1_addr !== 5'd0) begin errors++; $display("[TB] FAIL midrst rs1_addr: got %0d expected 0", rs1_addr); end
    issue(32'h01C12083, 32'h308, 32'd500, 32'd0);
    checks++; if (write_enable !== 1'b1 || write_rd !== 5'd1) begin
      errors++; $display("[TB] FAIL midrst load we/rd: got %b/%0d expected 1/1", write_enable, write_rd);
    end
    checks++; if (write_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL midrst load data: got %h expected cafef00d", write_data); end
    checks++; if (jump_dest !== 32'h30C) begin errors++; $display("[TB] FAIL midrst load jd: got %h expected 30c", jump_dest); end
  endtask

  initial begin
    test_reset();
    test_operand_addr();
    test_alu();
    test_control_flow();
    test_memory();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
